// File: rtl/prm_scan_pkg.sv
// Shared types and constants for the PRM edge-scan controller.
package prm_scan_pkg;

  // Width of one obstacle word (checker inputs A..O).
  localparam int OBS_W = 15;

  // Default bank geometry.
  localparam int DEF_NUM_EDGES = 512;
  localparam int DEF_LANES     = 16;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

  // Index width for a group counter; a single-group bank still gets a 1-bit index.
  function automatic int grp_width(input int groups);
    return (groups > 1) ? $clog2(groups) : 1;
  endfunction

endpackage

// File: rtl/prm_popcount.sv
// Combinational population count of one group's edge mask.
module prm_popcount
  import prm_scan_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int CNT_W = $clog2(LANES) + 1
) (
  input  logic [LANES-1:0] in_mask,
  output logic [CNT_W-1:0] count
);

  // Sum the set bits of the mask.
  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      count = count + CNT_W'(in_mask[i]);
    end
  end

endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// PRM edge-scan controller: latches one obstacle word, walks the checker bank
// group by group, and streams each group's edge mask out as a result beat while
// keeping a running count of blocked edges.
// Build option: define PRM_CHK_PIPE_EN when the checker bank has a registered
// output; each group then takes an issue cycle followed by a sample cycle.
module prm_edge_scan_ctrl
  import prm_scan_pkg::*;
#(
  parameter int NUM_EDGES = DEF_NUM_EDGES,
  parameter int LANES     = DEF_LANES
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  obs_valid,
  output logic                                  obs_ready,
  input  logic [OBS_W-1:0]                      obs_word,
  output logic [OBS_W-1:0]                      chk_obs,
  output logic [grp_width(NUM_EDGES/LANES)-1:0] chk_grp,
  input  logic [LANES-1:0]                      chk_mask,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [grp_width(NUM_EDGES/LANES)-1:0] res_grp,
  output logic [LANES-1:0]                      res_mask,
  output logic                                  res_last,
  output logic [$clog2(NUM_EDGES):0]            blk_cnt,
  output logic                                  busy
);

  localparam int GROUPS = NUM_EDGES / LANES;
  localparam int GRP_W  = grp_width(GROUPS);
  localparam int CNT_W  = $clog2(NUM_EDGES) + 1;
  localparam int PC_W   = $clog2(LANES) + 1;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);

  // Reject a bank that does not split into whole groups.
  if ((NUM_EDGES % LANES) != 0) begin : g_bad_cfg
    $error("prm_edge_scan_ctrl: NUM_EDGES must be a multiple of LANES");
  end

  scan_state_e      state_q, state_d;
  logic [OBS_W-1:0] chk_obs_q, chk_obs_d;
  logic [GRP_W-1:0] chk_grp_q, chk_grp_d;
  logic             res_valid_q, res_valid_d;
  logic [GRP_W-1:0] res_grp_q, res_grp_d;
  logic [LANES-1:0] res_mask_q, res_mask_d;
  logic             res_last_q, res_last_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
`ifdef PRM_CHK_PIPE_EN
  // 0 = chk_grp just issued to the registered bank, 1 = bank output valid.
  logic             phase_q, phase_d;
`endif

  logic [PC_W-1:0]  pop_cnt;
  logic             accept;
  logic             out_free;
  logic             sample_ok;
  logic             capture;
  logic             capture_last;
  logic             beat_done;
  logic             drain_done;

  prm_popcount #(
    .LANES (LANES),
    .CNT_W (PC_W)
  ) u_popcount (
    .in_mask (chk_mask),
    .count   (pop_cnt)
  );

  // Handshake and capture qualifiers shared by the FSM and datapath.
  always_comb begin
    accept       = (state_q == ST_IDLE) && obs_valid;
    out_free     = !res_valid_q || res_ready;
`ifdef PRM_CHK_PIPE_EN
    sample_ok    = phase_q;
`else
    sample_ok    = 1'b1;
`endif
    capture      = (state_q == ST_SCAN) && sample_ok && out_free;
    capture_last = capture && (chk_grp_q == LAST_GRP);
    beat_done    = res_valid_q && res_ready;
    drain_done   = (state_q == ST_DRAIN) && beat_done && res_last_q;
  end

  // State register and datapath flops with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values and
    // simulation ordering between always_ff blocks cannot change the result.
    if (rst) begin
      state_q     <= ST_IDLE;
      chk_obs_q   <= '0;
      chk_grp_q   <= '0;
      res_valid_q <= 1'b0;
      res_grp_q   <= '0;
      res_mask_q  <= '0;
      res_last_q  <= 1'b0;
      blk_cnt_q   <= '0;
`ifdef PRM_CHK_PIPE_EN
      phase_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      chk_obs_q   <= chk_obs_d;
      chk_grp_q   <= chk_grp_d;
      res_valid_q <= res_valid_d;
      res_grp_q   <= res_grp_d;
      res_mask_q  <= res_mask_d;
      res_last_q  <= res_last_d;
      blk_cnt_q   <= blk_cnt_d;
`ifdef PRM_CHK_PIPE_EN
      phase_q     <= phase_d;
`endif
    end
  end

  // Next-state logic: accept -> scan all groups -> wait for the last beat.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (obs_valid)    state_d = ST_SCAN;
      ST_SCAN:  if (capture_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done)   state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    obs_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
  end

  // Datapath: obstacle latch, group walk, output register and blocked count.
  always_comb begin
    chk_obs_d   = chk_obs_q;
    chk_grp_d   = chk_grp_q;
    res_valid_d = res_valid_q;
    res_grp_d   = res_grp_q;
    res_mask_d  = res_mask_q;
    res_last_d  = res_last_q;
    blk_cnt_d   = blk_cnt_q;
`ifdef PRM_CHK_PIPE_EN
    phase_d     = phase_q;
`endif

    if (accept) begin
      chk_obs_d = obs_word;
      chk_grp_d = '0;
      blk_cnt_d = '0;
`ifdef PRM_CHK_PIPE_EN
      phase_d   = 1'b0;
`endif
    end

`ifdef PRM_CHK_PIPE_EN
    // The issue cycle always advances; the sample cycle waits for room.
    if ((state_q == ST_SCAN) && !phase_q) begin
      phase_d = 1'b1;
    end
`endif

    // A beat leaving the register frees it unless refilled below.
    if (beat_done) begin
      res_valid_d = 1'b0;
      res_last_d  = 1'b0;
    end

    if (capture) begin
      res_valid_d = 1'b1;
      res_grp_d   = chk_grp_q;
      res_mask_d  = chk_mask;
      res_last_d  = (chk_grp_q == LAST_GRP);
      blk_cnt_d   = blk_cnt_q + CNT_W'(pop_cnt);
      chk_grp_d   = (chk_grp_q == LAST_GRP) ? '0 : chk_grp_q + 1'b1;
`ifdef PRM_CHK_PIPE_EN
      phase_d     = 1'b0;
`endif
    end
  end

  assign chk_obs   = chk_obs_q;
  assign chk_grp   = chk_grp_q;
  assign res_valid = res_valid_q;
  assign res_grp   = res_grp_q;
  assign res_mask  = res_mask_q;
  assign res_last  = res_last_q;
  assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// Scoreboard bench for prm_edge_scan_ctrl with a 64-edge, 16-lane bank model.
// Follows PRM_CHK_PIPE_EN: the bank model becomes registered and the expected
// scan length doubles per group.
module tb_prm_edge_scan_ctrl;
  import prm_scan_pkg::*;

  localparam int NE = 64;
  localparam int LN = 16;
`ifdef PRM_CHK_PIPE_EN
  localparam int EDGES_PER_GRP = 2;
`else
  localparam int EDGES_PER_GRP = 1;
`endif
  // Clock edges from the accepting edge until obs_ready is back: one per group
  // capture (two when pipelined) plus the edge that hands off the last beat.
  // Unpipelined that is 5 edges, i.e. obs_ready high in the sixth cycle after
  // the accept cycle.
  localparam int SCAN_EDGES = 4 * EDGES_PER_GRP + 1;

  typedef struct packed {
    logic [1:0]  grp;
    logic [15:0] mask;
    logic        last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              obs_valid;
  logic              obs_ready;
  logic [OBS_W-1:0]  obs_word;
  logic [OBS_W-1:0]  chk_obs;
  logic [1:0]        chk_grp;
  logic [LN-1:0]     chk_mask;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_grp;
  logic [LN-1:0]     res_mask;
  logic              res_last;
  logic [6:0]        blk_cnt;
  logic              busy;

  logic [15:0] bank_pat [4];
  beat_t       exp_q [$];
  beat_t       mon_e;
  int          checks   = 0;
  int          failures = 0;
  int          beats    = 0;

  prm_edge_scan_ctrl #(
    .NUM_EDGES (NE),
    .LANES     (LN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .obs_valid (obs_valid),
    .obs_ready (obs_ready),
    .obs_word  (obs_word),
    .chk_obs   (chk_obs),
    .chk_grp   (chk_grp),
    .chk_mask  (chk_mask),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_grp   (res_grp),
    .res_mask  (res_mask),
    .res_last  (res_last),
    .blk_cnt   (blk_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Checker bank model: mask per group from bank_pat.
`ifdef PRM_CHK_PIPE_EN
  always @(posedge clk) chk_mask <= bank_pat[chk_grp];
`else
  assign chk_mask = bank_pat[chk_grp];
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every beat the sink accepts must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got grp %0d mask %0h expected no beat", res_grp, res_mask);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_grp", 32'(res_grp), 32'(mon_e.grp));
        check("beat_mask", 32'(res_mask), 32'(mon_e.mask));
        check("beat_last", 32'(res_last), 32'(mon_e.last));
      end
      beats++;
    end
  end

  task automatic set_bank(input logic [15:0] p0, input logic [15:0] p1,
                          input logic [15:0] p2, input logic [15:0] p3);
    bank_pat[0] = p0;
    bank_pat[1] = p1;
    bank_pat[2] = p2;
    bank_pat[3] = p3;
  endtask

  // Queue the expected beats, then offer the word for one accepting edge.
  task automatic start_scan(input logic [14:0] w);
    check("ready_before_scan", 32'(obs_ready), 32'd1);
    beats = 0;
    for (int g = 0; g < 4; g++) begin
      exp_q.push_back(beat_t'{grp: 2'(g), mask: bank_pat[g], last: (g == 3)});
    end
    obs_word  = w;
    obs_valid = 1'b1;
    @(posedge clk);
    #1 obs_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!obs_ready && n < 200);
    if (!obs_ready) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic wait_until_grp(input logic [1:0] g, input bit on_result);
    int k = 0;
    while (k < 50 && !(on_result ? (res_valid && res_grp == g) : (chk_grp == g))) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("wait_grp_timeout", 32'(k < 50), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    obs_valid = 1'b0;
    obs_word  = '0;
    res_ready = 1'b1;
    set_bank(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_last", 32'(res_last), 32'd0);
    check("rst_res_mask", 32'(res_mask), 32'd0);
    check("rst_res_grp", 32'(res_grp), 32'd0);
    check("rst_chk_grp", 32'(chk_grp), 32'd0);
    check("rst_chk_obs", 32'(chk_obs), 32'd0);
    check("rst_blk_cnt", 32'(blk_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_obs_ready", 32'(obs_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full scan, all edges blocked, sink always ready.
    start_scan(15'h7FFF);
    check("a_busy", 32'(busy), 32'd1);
    check("a_ready_low", 32'(obs_ready), 32'd0);
    wait_idle(n);
    check("a_scan_edges", 32'(n), 32'(SCAN_EDGES));
    check("a_blk_cnt", 32'(blk_cnt), 32'd64);
    check("a_chk_obs", 32'(chk_obs), 32'h7FFF);
    check("a_beats", 32'(beats), 32'd4);
    check("a_queue_empty", 32'(exp_q.size()), 32'd0);

    // Sink stalls for three cycles on the group-1 beat.
    set_bank(16'h0001, 16'h0003, 16'h0007, 16'h000F);
    start_scan(15'h1234);
    wait_until_grp(2'd1, 1'b1);
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("b_hold_valid", 32'(res_valid), 32'd1);
      check("b_hold_grp", 32'(res_grp), 32'd1);
      check("b_hold_mask", 32'(res_mask), 32'h0003);
      check("b_hold_chk_grp", 32'(chk_grp), 32'd2);
    end
    res_ready = 1'b1;
    wait_idle(n);
    check("b_blk_cnt", 32'(blk_cnt), 32'd10);
    check("b_beats", 32'(beats), 32'd4);
    check("b_chk_obs", 32'(chk_obs), 32'h1234);
    check("b_queue_empty", 32'(exp_q.size()), 32'd0);

    // A new word offered mid-scan must be ignored.
    set_bank(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    start_scan(15'h7FFF);
    @(posedge clk);
    #1;
    obs_word  = 15'h0001;
    obs_valid = 1'b1;
    @(posedge clk);
    #1 obs_valid = 1'b0;
    check("c_chk_obs_mid", 32'(chk_obs), 32'h7FFF);
    check("c_busy_mid", 32'(busy), 32'd1);
    wait_idle(n);
    check("c_chk_obs_end", 32'(chk_obs), 32'h7FFF);
    check("c_blk_cnt", 32'(blk_cnt), 32'd64);
    check("c_beats", 32'(beats), 32'd4);
    repeat (2) @(posedge clk);
    #1;
    check("c_no_restart", 32'(busy), 32'd0);
    check("c_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a scan discards it.
    start_scan(15'h2AAA);
    wait_until_grp(2'd2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("d_res_valid", 32'(res_valid), 32'd0);
    check("d_obs_ready", 32'(obs_ready), 32'd1);
    check("d_blk_cnt", 32'(blk_cnt), 32'd0);
    check("d_busy", 32'(busy), 32'd0);
    check("d_chk_grp", 32'(chk_grp), 32'd0);
    check("d_chk_obs", 32'(chk_obs), 32'd0);
    check("d_res_last", 32'(res_last), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;

    // Sparse mask per group; scan length tracks the bank latency.
    set_bank(16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0);
    start_scan(15'h4321);
    wait_idle(n);
    check("e_scan_edges", 32'(n), 32'(SCAN_EDGES));
    check("e_blk_cnt", 32'(blk_cnt), 32'd16);
    check("e_beats", 32'(beats), 32'd4);
    check("e_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
